// File: rtl/qdec_bs_fetch.sv
// qdec_bs_fetch: bitstream fetch controller for the CABAC decoder byte input.
// Walks a byte range of the bitstream RAM on `start`, issuing at most one read
// per cycle under a FIFO credit limit. Returned bytes are optionally filtered
// for HEVC emulation-prevention bytes, buffered, and streamed out on a
// valid/ready byte port.
//
// Optional feature macro: QDEC_BS_FETCH_EPB_EN (emulation-prevention removal).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start/start_addr/byte_len  transfer command (ignored while busy)
//   abort                    cancel current transfer, no done pulse
//   busy, done               status; done pulses one cycle at completion
//   ram_addr, ram_re, ram_dout  RAM read port (1-cycle read latency)
//   bitstreamFetch[_vld/_rdy]   output byte stream
//   epb_cnt                  emulation-prevention bytes dropped this/last transfer
module qdec_bs_fetch #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] byte_len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_re,
  input  logic [7:0]        ram_dout,
  output logic [7:0]        bitstreamFetch,
  output logic              bitstreamFetch_vld,
  input  logic              bitstreamFetch_rdy,
  output logic [15:0]       epb_cnt
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [ADDR_W-1:0] remain_q, remain_n;
  logic [ADDR_W-1:0] ram_addr_n;
  logic              ram_re_n;
  logic              rvalid_q;
  logic              abort_act, start_go;
  logic              push, pop, drop;
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count_q, count_n;
  logic [CNT_W:0]    credit_used;
  logic              credit_ok;

  assign abort_act = abort && (state_q != S_IDLE);
  assign start_go  = start && !abort && (state_q == S_IDLE);

  // FIFO handshake; a byte returning while aborting is discarded
  assign bitstreamFetch_vld = (count_q != '0);
  assign bitstreamFetch     = fifo_mem[rd_ptr];
  assign pop  = bitstreamFetch_vld && bitstreamFetch_rdy;
  assign push = rvalid_q && !drop && !abort_act;

  always_comb begin
    count_n = count_q + CNT_W'(push) - CNT_W'(pop);
    if (abort_act) count_n = '0;
  end

  // Next cycle holds count_n buffered bytes plus the read returning from this
  // cycle; one more read is allowed only if all of them still fit the FIFO.
  assign credit_used = {1'b0, count_n} + (CNT_W+1)'(ram_re);
  assign credit_ok   = credit_used < (CNT_W+1)'(FIFO_DEPTH);

  // Next-state and read-issue decode
  always_comb begin
    state_n    = state_q;
    addr_n     = addr_q;
    remain_n   = remain_q;
    ram_re_n   = 1'b0;
    ram_addr_n = ram_addr;
    unique case (state_q)
      S_IDLE: begin
        if (start_go) begin
          if (byte_len == '0) begin
            state_n = S_DONE;
          end else begin
            state_n    = S_FETCH;
            ram_re_n   = 1'b1;
            ram_addr_n = start_addr;
            addr_n     = start_addr + ADDR_W'(1);
            remain_n   = byte_len - ADDR_W'(1);
          end
        end
      end
      S_FETCH: begin
        if (remain_q == '0) begin
          state_n = S_DRAIN;
        end else if (credit_ok) begin
          ram_re_n   = 1'b1;
          ram_addr_n = addr_q;
          addr_n     = addr_q + ADDR_W'(1);
          remain_n   = remain_q - ADDR_W'(1);
          if (remain_q == ADDR_W'(1)) state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!ram_re && (count_n == '0)) state_n = S_DONE;
      end
      S_DONE: state_n = S_IDLE;
    endcase
    if (abort_act) begin
      state_n  = S_IDLE;
      ram_re_n = 1'b0;
      remain_n = '0;
    end
  end

  // State and registered control outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      ram_re   <= 1'b0;
      ram_addr <= '0;
      rvalid_q <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_n;
      addr_q   <= addr_n;
      remain_q <= remain_n;
      ram_re   <= ram_re_n;
      ram_addr <= ram_addr_n;
      rvalid_q <= ram_re && !abort_act;
      busy     <= (state_n != S_IDLE);
      done     <= (state_n == S_DONE);
    end
  end

  // Output FIFO storage and pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      assert (!(push && (count_q == CNT_W'(FIFO_DEPTH))));
      count_q <= count_n;
      if (abort_act) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          fifo_mem[wr_ptr] <= ram_dout;
          wr_ptr           <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

`ifdef QDEC_BS_FETCH_EPB_EN
  logic [1:0]  zrun_q;
  logic [15:0] epb_q;

  // 00 00 03 drops the 03; the zero run saturates at two
  assign drop = rvalid_q && (zrun_q == 2'd2) && (ram_dout == 8'h03);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zrun_q <= '0;
      epb_q  <= '0;
    end else if (abort_act) begin
      zrun_q <= '0;
    end else if (start_go) begin
      zrun_q <= '0;
      epb_q  <= '0;
    end else if (rvalid_q) begin
      if (drop) begin
        zrun_q <= '0;
        if (epb_q != 16'hFFFF) epb_q <= epb_q + 16'd1;
      end else if (ram_dout == 8'h00) begin
        if (zrun_q != 2'd2) zrun_q <= zrun_q + 2'd1;
      end else begin
        zrun_q <= '0;
      end
    end
  end

  assign epb_cnt = epb_q;
`else
  assign drop    = 1'b0;
  assign epb_cnt = '0;
`endif

endmodule

// File: tb/tb_qdec_bs_fetch.sv
// Self-checking bench for qdec_bs_fetch: RAM model, scoreboard of expected
// output bytes, and directed transfers (basic, backpressure, EPB, zero length,
// address wrap, abort, asynchronous reset).
module tb_qdec_bs_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, rdy;
  logic [15:0] start_addr, byte_len, ram_addr, epb_cnt;
  logic [7:0]  ram_dout, bs;
  logic        busy, done, ram_re, vld;

  logic [7:0]  ram_mem [65536];
  logic [7:0]  exp_q [$];
  logic [15:0] addr_log [$];

  int n_tests = 0, n_fail = 0;
  int cyc = 0, issued = 0, pops = 0, max_out = 0;
  int done_cnt = 0, done_cyc = -1, first_pop = -1, last_pop = -1;
  int exp_epb = 0;

  qdec_bs_fetch dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .byte_len(byte_len), .abort(abort), .busy(busy), .done(done),
    .ram_addr(ram_addr), .ram_re(ram_re), .ram_dout(ram_dout),
    .bitstreamFetch(bs), .bitstreamFetch_vld(vld),
    .bitstreamFetch_rdy(rdy), .epb_cnt(epb_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM with one cycle of latency
  always @(posedge clk) if (ram_re) ram_dout <= ram_mem[ram_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance to the next falling edge and sample that cycle
  task automatic step();
    @(negedge clk);
    cyc++;
    if (ram_re) begin
      addr_log.push_back(ram_addr);
      issued++;
    end
    if (issued - pops > max_out) max_out = issued - pops;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (vld && rdy) begin
      if (exp_q.size() == 0) check("extra_byte", 32'(exp_q.size()), 32'd1);
      else check("byte", 32'(bs), 32'(exp_q.pop_front()));
      pops++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
  endtask

  task automatic clr_mon();
    issued = 0; pops = 0; max_out = 0; done_cnt = 0;
    done_cyc = -1; first_pop = -1; last_pop = -1;
    addr_log.delete();
  endtask

  // Reference model: expected byte stream and EPB count for a RAM range
  task automatic expect_range(input logic [15:0] a, input int len);
    int z;
    logic [7:0] b;
    z = 0;
    exp_epb = 0;
    for (int i = 0; i < len; i++) begin
      b = ram_mem[16'(a + 16'(i))];
`ifdef QDEC_BS_FETCH_EPB_EN
      if (z == 2 && b == 8'h03) begin
        exp_epb++;
        z = 0;
        continue;
      end
      if (b == 8'h00) z = (z == 2) ? 2 : z + 1;
      else z = 0;
`endif
      exp_q.push_back(b);
    end
  endtask

  task automatic do_start(input logic [15:0] a, input logic [15:0] len);
    start = 1'b1; start_addr = a; byte_len = len;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int base, n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < budget) begin
      step();
      n++;
    end
    if (done_cnt == base) check("done_timeout", 32'(n), 32'(budget + 1));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_re"},    32'(ram_re), 32'd0);
    check({tag, "_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_byte"}, 32'(bs), 32'd0);
    check({tag, "_vld"},  32'(vld), 32'd0);
    check({tag, "_epb"},  32'(epb_cnt), 32'd0);
  endtask

  initial begin
    logic [7:0] epb_pat [8];
    epb_pat = '{8'h00, 8'h00, 8'h03, 8'h01, 8'h00, 8'h00, 8'h03, 8'h03};
    for (int i = 0; i < 8; i++)  ram_mem[16'h0010 + i] = 8'(16 + i);
    for (int i = 0; i < 16; i++) ram_mem[16'h0200 + i] = 8'(8'h80 + i);
    for (int i = 0; i < 8; i++)  ram_mem[16'h0100 + i] = epb_pat[i];
    ram_mem[16'hFFFE] = 8'hA1; ram_mem[16'hFFFF] = 8'hA2;
    ram_mem[16'h0000] = 8'hA3; ram_mem[16'h0001] = 8'hA4;

    rst = 1'b1; start = 1'b0; abort = 1'b0; rdy = 1'b1;
    start_addr = '0; byte_len = '0;
    step(); step();
    check_reset_vals("rst");
    rst = 1'b0;
    step();

    // Basic transfer: 0x10..0x17, latency 3, back-to-back bytes
    clr_mon();
    expect_range(16'h0010, 8);
    do_start(16'h0010, 16'd8);
    check("basic_re", 32'(ram_re), 32'd1);
    check("basic_addr", 32'(ram_addr), 32'h10);
    check("basic_busy", 32'(busy), 32'd1);
    step();
    check("basic_vld_n2", 32'(vld), 32'd0);
    step();
    check("basic_vld_n3", 32'(vld), 32'd1);
    check("basic_first", 32'(first_pop), 32'(cyc));
    wait_done(100);
    check("basic_span", 32'(last_pop - first_pop), 32'd7);
    check("basic_done_cyc", 32'(done_cyc), 32'(last_pop + 1));
    check("basic_pops", 32'(pops), 32'd8);
    step();
    check("basic_done_once", 32'(done_cnt), 32'd1);
    check("basic_idle", 32'(busy), 32'd0);

    // Backpressure, with a start pulse while busy that must be ignored
    clr_mon();
    expect_range(16'h0010, 8);
    do_start(16'h0010, 16'd8);
    for (int c = 1; c <= 12; c++) begin
      if (c == 3)  rdy = 1'b0;
      if (c == 10) rdy = 1'b1;
      if (c == 5) begin start = 1'b1; start_addr = 16'h0200; byte_len = 16'd2; end
      if (c == 6) start = 1'b0;
      step();
    end
    wait_done(100);
    check("bp_max_out", 32'(max_out), 32'd4);
    check("bp_pops", 32'(pops), 32'd8);
    check("bp_done_cyc", 32'(done_cyc), 32'(last_pop + 1));
    step(); step();
    check("bp_done_once", 32'(done_cnt), 32'd1);
    check("bp_sb_left", 32'(exp_q.size()), 32'd0);

    // Emulation-prevention pattern
    clr_mon();
    expect_range(16'h0100, 8);
`ifdef QDEC_BS_FETCH_EPB_EN
    check("epb_model_len", 32'(exp_q.size()), 32'd6);
`else
    check("epb_model_len", 32'(exp_q.size()), 32'd8);
`endif
    do_start(16'h0100, 16'd8);
    wait_done(100);
    check("epb_cnt", 32'(epb_cnt), 32'(exp_epb));
    check("epb_pops", 32'(pops), 32'(8 - exp_epb));
    check("epb_sb_left", 32'(exp_q.size()), 32'd0);
    step();

    // Zero length
    clr_mon();
    do_start(16'h0040, 16'd0);
    check("zl_done", 32'(done), 32'd1);
    check("zl_re", 32'(ram_re), 32'd0);
    step();
    check("zl_done_drop", 32'(done), 32'd0);
    check("zl_idle", 32'(busy), 32'd0);
    check("zl_reads", 32'(issued), 32'd0);

    // Address wrap
    clr_mon();
    expect_range(16'hFFFE, 4);
    do_start(16'hFFFE, 16'd4);
    wait_done(100);
    check("wrap_nreads", 32'(addr_log.size()), 32'd4);
    if (addr_log.size() == 4) begin
      check("wrap_a0", 32'(addr_log[0]), 32'hFFFE);
      check("wrap_a1", 32'(addr_log[1]), 32'hFFFF);
      check("wrap_a2", 32'(addr_log[2]), 32'h0000);
      check("wrap_a3", 32'(addr_log[3]), 32'h0001);
    end
    check("wrap_sb_left", 32'(exp_q.size()), 32'd0);
    step();

    // Abort after the third output byte
    clr_mon();
    expect_range(16'h0200, 16);
    do_start(16'h0200, 16'd16);
    for (int n = 0; n < 50 && pops < 3; n++) step();
    check("abort_reach3", 32'(pops), 32'd3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    exp_q.delete();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_vld", 32'(vld), 32'd0);
    repeat (6) step();
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_pops", 32'(pops), 32'd3);
    clr_mon();
    expect_range(16'h0010, 4);
    do_start(16'h0010, 16'd4);
    check("restart_addr", 32'(ram_addr), 32'h10);
    wait_done(100);
    check("restart_pops", 32'(pops), 32'd4);
    check("restart_sb_left", 32'(exp_q.size()), 32'd0);
    step();

    // Asynchronous reset during FETCH
    clr_mon();
    expect_range(16'h0200, 16);
    do_start(16'h0200, 16'd16);
    repeat (3) step();
    check("mid_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_vals("arst");
    exp_q.delete();
    step();
    rst = 1'b0;
    step();
    clr_mon();
    expect_range(16'h0010, 4);
    do_start(16'h0010, 16'd4);
    wait_done(100);
    check("post_rst_pops", 32'(pops), 32'd4);
    check("post_rst_sb_left", 32'(exp_q.size()), 32'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qdec_bs_fetch.md
# qdec_bs_fetch

Bitstream fetch controller feeding the CABAC decoder's byte input. On a `start` command it walks a byte range of the external bitstream RAM and issues one read per cycle under a credit limit. It optionally strips HEVC emulation-prevention bytes, buffers the bytes in a small FIFO, and presents them on a valid/ready byte stream that connects directly to the decoder's `bitstreamFetch`/`bitstreamFetch_vld`/`bitstreamFetch_rdy` port.

## Interface

- `ADDR_W`, 16, RAM byte-address width; also the width of `byte_len`
- `FIFO_DEPTH`, 4, output FIFO entries; power of two, ≥2

- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  one-cycle command pulse; ignored while `busy`
- `start_addr`  in  ADDR_W  first byte address, sampled with `start`
- `byte_len`  in  ADDR_W  number of RAM bytes to read, sampled with `start`
- `abort`  in  1  cancel current transfer
- `busy`  out  1  high in any state except IDLE
- `done`  out  1  one-cycle pulse when the transfer completes (never on abort)
- `ram_addr`  out  ADDR_W  read address
- `ram_re`  out  1  read enable; data returns on `ram_dout` exactly 1 cycle later
- `ram_dout`  in  8  RAM read data
- `bitstreamFetch`  out  8  output byte
- `bitstreamFetch_vld`  out  1  output valid
- `bitstreamFetch_rdy`  in  1  consumer ready
- `epb_cnt`  out  16  number of emulation-prevention bytes dropped in the current or last transfer

## Operation

- States: IDLE, FETCH, DRAIN, DONE.
- IDLE → FETCH on `start`. The block loads `addr`=`start_addr`, `remain`=`byte_len`, clears `epb_cnt` and the zero-run counter. If `byte_len`==0, it goes IDLE → DONE instead.
- FETCH: `ram_re`=1 when `remain`≠0 and `fifo_count + inflight < FIFO_DEPTH`. `inflight` is 0 or 1. On each read, `addr`+1 (wraps modulo 2^ADDR_W) and `remain`−1. When the last read issues, FETCH → DRAIN.
- DRAIN → DONE when `inflight`==0 and the FIFO is empty.
- DONE: `done`=1 for one cycle, then → IDLE.
- Returned byte: passes through the EPB filter (see Configuration), then is pushed into the FIFO. There is no overflow by construction; a push to a full FIFO is a design error, asserted in simulation.
- FIFO head drives `bitstreamFetch`. `bitstreamFetch_vld` = FIFO not empty. A pop occurs when `vld && rdy`. Push and pop in the same cycle leave the count unchanged.
- `abort` (any state except IDLE): next state IDLE, with FIFO, `inflight`, `remain` and the zero-run counter cleared. The RAM byte returning in the cycle after abort is discarded. No `done` pulse. `abort` has priority over `start` in the same cycle.
- `start` while `busy`: ignored with no effect.

## Timing

- Reset values: `busy`=0, `done`=0, `ram_re`=0, `ram_addr`=0, `bitstreamFetch`=0, `bitstreamFetch_vld`=0, `epb_cnt`=0. FIFO is empty and the state is IDLE.
- `start` sampled at edge N:
  - first `ram_re` in cycle N+1
  - data is present on `ram_dout` in N+2 and written at the end of N+2
  - `bitstreamFetch_vld` rises in cycle N+3
- Start-to-first-byte latency: 3 cycles.
- Throughput: 1 byte/cycle sustained when `rdy` is held high.
- `done` is asserted in the cycle after the last pop of the transfer.
- While `vld && !rdy`, `bitstreamFetch` stays stable.
- Registered outputs: `ram_re`, `ram_addr`, `busy`, `done`. `bitstreamFetch` comes from the FIFO storage read.

## Configuration

- `QDEC_BS_FETCH_EPB_EN` defined: emulation-prevention removal is active.
  - A zero-run counter saturates at 2 and counts consecutive 0x00 bytes in the RAM byte stream.
  - If a byte is 0x03 while the count is 2, that byte is dropped (not pushed), the count resets to 0, and `epb_cnt` increments (saturating at 0xFFFF).
  - Otherwise a 0x00 byte increments the count and any other byte clears it.
  - Dropped bytes still count against `byte_len`.
- Not defined: every RAM byte is pushed unchanged, `epb_cnt` is tied to 0, and no filter logic is instantiated.

## Test plan

- Basic transfer: `start_addr`=0x0010, `byte_len`=8, RAM[i]=i, `rdy`=1 → bytes 0x10..0x17 appear on 8 consecutive cycles starting at N+3, and `done` pulses once in the cycle after the last byte.
- Backpressure: same transfer with `rdy` low for cycles 4..10 → `ram_re` stops after 4 reads are outstanding/buffered, there is no byte loss or duplication, and the output order is unchanged.
- EPB (macro on): RAM = 00 00 03 01 00 00 03 03, `byte_len`=8 → output 00 00 01 00 00 03 and `epb_cnt`=2. With the macro off, all 8 bytes are output unchanged and `epb_cnt`=0.
- Zero length and wrap: `byte_len`=0 → `done` pulses at N+1 with no `ram_re`. `start_addr`=0xFFFE, `byte_len`=4 → addresses FFFE, FFFF, 0000, 0001.
- Abort mid-transfer: `abort` raised after the 3rd output byte of a 16-byte run → IDLE next cycle, `vld`=0, no `done`. A subsequent `start` runs cleanly from its own `start_addr`.
- Reset mid-transfer: `rst` asserted during FETCH → all outputs return to their reset values immediately (asynchronous reset).
